// File: rtl/atm_cell_rewriter.sv
// rtl/atm_cell_rewriter.sv - UNI to NNI ATM cell header rewriter
// Checks input HEC, maps VPI through an external table and regenerates HEC.
module atm_cell_rewriter #(
  parameter int NumTx    = 4,
  parameter bit CheckHec = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_soc,
  output logic [7:0]          lut_addr,
  input  logic [NumTx+11:0]   lut_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_soc,
  output logic                out_eoc,
  output logic [NumTx-1:0]    out_fwd,
  output logic                drop_hec,
  output logic                drop_nofwd
);

  typedef enum logic [2:0] {IDLE, HDR, LOOKUP, EMIT, PAYLOAD, DISCARD} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [5:0]        pay_q, pay_d;
  logic [4:0][7:0]   hdr_q, hdr_d;
  logic [7:0]        lut_addr_q, lut_addr_d;
  logic [NumTx-1:0]  fwd_q, fwd_d;
  logic              alive_q, alive_d;

  logic [NumTx-1:0]  lut_fwd;
  logic [11:0]       lut_vpi;
  logic [7:0]        nni0, nni1, new_hec;
  logic              hdr_ok;

  // CRC-8 x^8+x^2+x+1, init 0, MSB first, coset 0x55
  function automatic logic [7:0] hec_of(input logic [31:0] h);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ h[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c ^ 8'h55;
  endfunction

  assign lut_fwd  = lut_rdata[NumTx+11:12];
  assign lut_vpi  = lut_rdata[11:0];
  assign nni0     = lut_vpi[11:4];
  assign nni1     = {lut_vpi[3:0], hdr_q[1][3:0]};
  assign hdr_ok   = (hec_of({hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3]}) == hdr_q[4]);
  assign new_hec  = hec_of({nni0, nni1, hdr_q[2], hdr_q[3]});
  assign lut_addr = lut_addr_q;
  assign out_fwd  = fwd_q;
  assign alive_d  = 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pay_d      = pay_q;
    hdr_d      = hdr_q;
    lut_addr_d = lut_addr_q;
    fwd_d      = fwd_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_soc    = 1'b0;
    out_eoc    = 1'b0;
    drop_hec   = 1'b0;
    drop_nofwd = 1'b0;
    case (state_q)
      IDLE: begin
        // alive_q keeps in_ready low until the first edge after reset release
        in_ready = alive_q;
        if (in_valid && alive_q && in_soc) begin
          hdr_d[0] = in_data;
          cnt_d    = 3'd1;
          state_d  = HDR;
        end
      end
      HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_soc) begin
            hdr_d[0] = in_data;
            cnt_d    = 3'd1;
          end else begin
            hdr_d[cnt_q] = in_data;
            if (cnt_q == 3'd1) lut_addr_d = {hdr_q[0][3:0], in_data[7:4]};
            if (cnt_q == 3'd4) begin
              cnt_d   = 3'd0;
              state_d = LOOKUP;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end
      LOOKUP: begin
        pay_d = 6'd0;
        if (CheckHec && !hdr_ok) begin
          drop_hec = 1'b1;
          state_d  = DISCARD;
        end else if (lut_fwd == '0) begin
          drop_nofwd = 1'b1;
          state_d    = DISCARD;
        end else begin
          fwd_d    = lut_fwd;
          hdr_d[0] = nni0;
          hdr_d[1] = nni1;
          hdr_d[4] = new_hec;
          cnt_d    = 3'd0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = hdr_q[cnt_q];
        out_soc   = (cnt_q == 3'd0);
        if (out_ready) begin
          if (cnt_q == 3'd4) begin
            pay_d   = 6'd0;
            state_d = PAYLOAD;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      PAYLOAD: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        out_eoc   = (pay_q == 6'd47);
        if (in_valid && out_ready) begin
          if (pay_q == 6'd47) state_d = IDLE;
          else                pay_d   = pay_q + 6'd1;
        end
      end
      DISCARD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (pay_q == 6'd47) state_d = IDLE;
          else                pay_d   = pay_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      pay_q      <= 6'd0;
      hdr_q      <= '0;
      lut_addr_q <= 8'h00;
      fwd_q      <= '0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pay_q      <= pay_d;
      hdr_q      <= hdr_d;
      lut_addr_q <= lut_addr_d;
      fwd_q      <= fwd_d;
      alive_q    <= alive_d;
    end
  end

endmodule
